// File: rtl/ddmtd_pkg.sv
// ---------------------------------------------------------------------------
// ddmtd_pkg
// Shared definitions for the DDMTD measurement controller:
//   - default values of the tag counter width, maximum averaging exponent
//     and wait-state timeout
//   - the derived accumulator width
//   - the measurement FSM state type
//   - a helper that clamps the requested averaging exponent
// ---------------------------------------------------------------------------
package ddmtd_pkg;

    localparam int CNT_W_DEF    = 16;
    localparam int NAVG_MAX_DEF = 4;
    localparam int TIMEOUT_DEF  = 65535;

    // Summing 2^NAVG_MAX differences of CNT_W bits each needs NAVG_MAX
    // extra bits, so the accumulator can never overflow.
    localparam int ACC_W_DEF = CNT_W_DEF + NAVG_MAX_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_A,
        ST_WAIT_B,
        ST_ACCUM,
        ST_DONE
    } meas_state_e;

    // Requests above the supported maximum are limited to that maximum
    // rather than rejected.
    function automatic logic [2:0] clamp_navg(input logic [2:0] navg,
                                              input int         navg_max);
        if (32'(navg) > 32'(navg_max)) begin
            return 3'(navg_max);
        end
        return navg;
    endfunction

endpackage

// File: rtl/ddmtd_edge_tagger.sv
// ---------------------------------------------------------------------------
// ddmtd_edge_tagger
// Detects rising edges on one (already synchronized) DDMTD beat and tags
// them with the value of the shared free-running tag counter.
//
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   beat_i     - beat input, synchronous to clk
//   tag_cnt_i  - current value of the free-running tag counter
//   rise_o     - high in the cycle a rising edge is detected
//   tag_o      - tag of the edge: the counter value in the detection cycle
//                while rise_o is high, otherwise the last captured tag
// ---------------------------------------------------------------------------
module ddmtd_edge_tagger
    import ddmtd_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat_i,
    input  logic [CNT_W-1:0] tag_cnt_i,
    output logic             rise_o,
    output logic [CNT_W-1:0] tag_o
);

    logic             prev_q;
    logic [CNT_W-1:0] last_tag_q;

    // The previous-level register resets high so that a beat which is
    // already high when reset is released is not mistaken for an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= 1'b1;
            last_tag_q <= '0;
        end else begin
            prev_q <= beat_i;
            if (rise_o) begin
                last_tag_q <= tag_cnt_i;
            end
        end
    end

    assign rise_o = beat_i & ~prev_q;

    // The live counter value is forwarded in the detection cycle so the
    // controller can use the tag without an extra cycle of latency.
    assign tag_o = rise_o ? tag_cnt_i : last_tag_q;

endmodule

// File: rtl/ddmtd_meas_ctrl.sv
// ---------------------------------------------------------------------------
// ddmtd_meas_ctrl
// DDMTD phase measurement controller. Tags rising edges of the two beat
// signals with a free-running counter, measures the B-minus-A tag difference
// for 2^navg edge pairs, averages them and reports the result.
//
// Parameters:
//   CNT_W     - width of tag counter, phase difference and result
//   NAVG_MAX  - maximum log2 of the number of averaged pairs
//   TIMEOUT   - maximum cycles spent in WAIT_A or WAIT_B
//
// Ports:
//   clk           - the only clock
//   rst           - synchronous active-high reset
//   start         - begin a measurement (accepted in IDLE only)
//   abort         - cancel a running measurement
//   navg          - log2 of pair count, sampled on start, clamped
//   beat_a        - DDMTD beat A, synchronous to clk
//   beat_b        - DDMTD beat B, synchronous to clk
//   busy          - high whenever the FSM is not in IDLE
//   result        - averaged B-minus-A tag difference
//   result_valid  - one-cycle pulse when result updates
//   err           - timeout flag, sticky until the next accepted start
// ---------------------------------------------------------------------------
module ddmtd_meas_ctrl
    import ddmtd_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int NAVG_MAX = NAVG_MAX_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       navg,
    input  logic             beat_a,
    input  logic             beat_b,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             err
);

    localparam int ACC_W  = CNT_W + NAVG_MAX;
    localparam int PAIR_W = NAVG_MAX + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    meas_state_e      state_q;
    logic [CNT_W-1:0] tag_cnt_q;
    logic [CNT_W-1:0] tag_cnt_d;
    logic [2:0]       navg_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [PAIR_W-1:0] pair_cnt_q;
    logic [PAIR_W-1:0] pair_cnt_d;
    logic [PAIR_W-1:0] pair_target;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic             timeout_hit;
    logic [CNT_W-1:0] tag_a_q;
    logic [CNT_W-1:0] diff_q;
    logic [CNT_W-1:0] result_q;
    logic             result_valid_q;
    logic             err_q;

    logic             rise_a;
    logic             rise_b;
    logic [CNT_W-1:0] tag_a;
    logic [CNT_W-1:0] tag_b;

    ddmtd_edge_tagger #(
        .CNT_W (CNT_W)
    ) u_tagger_a (
        .clk       (clk),
        .rst       (rst),
        .beat_i    (beat_a),
        .tag_cnt_i (tag_cnt_q),
        .rise_o    (rise_a),
        .tag_o     (tag_a)
    );

    ddmtd_edge_tagger #(
        .CNT_W (CNT_W)
    ) u_tagger_b (
        .clk       (clk),
        .rst       (rst),
        .beat_i    (beat_b),
        .tag_cnt_i (tag_cnt_q),
        .rise_o    (rise_b),
        .tag_o     (tag_b)
    );

    // Next-state values shared by several FSM branches. The tag counter
    // wraps naturally at its width. The timeout fires on the cycle whose
    // incremented wait count would reach TIMEOUT, so the FSM is back in
    // IDLE exactly TIMEOUT cycles after entering a wait state.
    always_comb begin
        tag_cnt_d   = tag_cnt_q + 1'b1;
        acc_d       = acc_q + ACC_W'(diff_q);
        pair_cnt_d  = pair_cnt_q + 1'b1;
        pair_target = PAIR_W'(1) << navg_q;
        wait_cnt_d  = wait_cnt_q + 1'b1;
        timeout_hit = (32'(wait_cnt_d) >= 32'(TIMEOUT));
    end

    // Measurement FSM with accumulator, pair and wait counters.
    // abort outranks every edge and start; rst outranks everything.
    // The averaged result is computed on the ACCUM -> DONE transition so
    // that result and result_valid are both presented during the DONE
    // cycle, two cycles after the final B edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            tag_cnt_q      <= '0;
            navg_q         <= '0;
            acc_q          <= '0;
            pair_cnt_q     <= '0;
            wait_cnt_q     <= '0;
            tag_a_q        <= '0;
            diff_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            tag_cnt_q      <= tag_cnt_d;
            result_valid_q <= 1'b0;

            if (abort && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            navg_q     <= clamp_navg(navg, NAVG_MAX);
                            acc_q      <= '0;
                            pair_cnt_q <= '0;
                            err_q      <= 1'b0;
                            wait_cnt_q <= '0;
                            state_q    <= ST_WAIT_A;
                        end
                    end

                    ST_WAIT_A: begin
                        if (rise_a && rise_b) begin
                            diff_q  <= '0;
                            state_q <= ST_ACCUM;
                        end else if (rise_a) begin
                            tag_a_q    <= tag_a;
                            wait_cnt_q <= '0;
                            state_q    <= ST_WAIT_B;
                        end else if (timeout_hit) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            wait_cnt_q <= wait_cnt_d;
                        end
                    end

                    // A later A edge replaces the reference tag; it is not a
                    // new entry into WAIT_B, so the wait count keeps running.
                    ST_WAIT_B: begin
                        if (rise_b) begin
                            diff_q  <= tag_b - tag_a_q;
                            state_q <= ST_ACCUM;
                        end else begin
                            if (rise_a) begin
                                tag_a_q <= tag_a;
                            end
                            if (timeout_hit) begin
                                err_q   <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                wait_cnt_q <= wait_cnt_d;
                            end
                        end
                    end

                    ST_ACCUM: begin
                        acc_q      <= acc_d;
                        pair_cnt_q <= pair_cnt_d;
                        if (pair_cnt_d == pair_target) begin
                            result_q       <= CNT_W'(acc_d >> navg_q);
                            result_valid_q <= 1'b1;
                            state_q        <= ST_DONE;
                        end else begin
                            wait_cnt_q <= '0;
                            state_q    <= ST_WAIT_A;
                        end
                    end

                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_ddmtd_meas_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ddmtd_meas_ctrl
// Self-checking bench for ddmtd_meas_ctrl. Directed measurements push their
// hand-computed result and the tag of the cycle in which result_valid is due
// into a queue; a monitor pops an entry whenever result_valid is seen.
// ---------------------------------------------------------------------------
module tb_ddmtd_meas_ctrl;

    typedef struct {
        int res;
        int due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [2:0]  navg;
    logic        beat_a;
    logic        beat_b;
    logic        busy;
    logic [15:0] result;
    logic        result_valid;
    logic        err;

    logic [15:0] tbTag;
    exp_t        expQ[$];
    int          compared;
    int          failed;

    ddmtd_meas_ctrl #(
        .CNT_W    (16),
        .NAVG_MAX (4),
        .TIMEOUT  (1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .navg         (navg),
        .beat_a       (beat_a),
        .beat_b       (beat_b),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .err          (err)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference tag: counts cycles since reset release, wrapping at 16 bits,
    // so directed edges can be placed at absolute tag values.
    always @(posedge clk) begin
        if (rst) begin
            tbTag <= '0;
        end else begin
            tbTag <= tbTag + 16'd1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tag %0d)",
                     name, actual, expected, tbTag);
        end
    endtask

    // Monitor: every result_valid must match the oldest queued expectation,
    // both in value and in the cycle it appears.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                compared++;
                failed++;
                $display("[TB] FAIL unexpectedValid: got result_valid=1 result=%0d at tag %0d, expected no result", result, tbTag);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("result", 32'(result), e.res);
                checkOutput("validTag", 32'(tbTag), e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitTag(input int t);
        int n;
        n = 0;
        while ((int'(tbTag) != t) && (n < 70000)) begin
            tick();
            n++;
        end
        if (int'(tbTag) != t) begin
            compared++;
            failed++;
            $display("[TB] FAIL waitTag: got tag %0d, expected tag %0d", tbTag, t);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic ab, input logic a,
                                 input logic b, input logic [2:0] nv);
        start  = s;
        abort  = ab;
        beat_a = a;
        beat_b = b;
        navg   = nv;
        tick();
        start  = 1'b0;
        abort  = 1'b0;
        beat_a = 1'b0;
        beat_b = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: still running at time %0t, expected to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int aTags[4];
        int diffs[4];
        compared = 0;
        failed   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        navg     = 3'd0;
        beat_a   = 1'b0;
        beat_b   = 1'b0;

        // Reset state
        repeat (3) tick();
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstResult", 32'(result), 0);
        checkOutput("rstValid", 32'(result_valid), 0);
        checkOutput("rstErr", 32'(err), 0);
        rst = 1'b0;

        // Single pair: A at 100, B at 350 -> 250, valid at 352, idle at 353.
        // A second start while busy must be ignored.
        waitTag(90);
        applyStimulus(1, 0, 0, 0, 3'd0);
        checkOutput("t1Busy", 32'(busy), 1);
        waitTag(100);
        applyStimulus(0, 0, 1, 0, 3'd0);
        waitTag(200);
        applyStimulus(1, 0, 0, 0, 3'd3);
        waitTag(350);
        expQ.push_back('{res: 250, due: 352});
        applyStimulus(0, 0, 0, 1, 3'd0);
        waitTag(352);
        checkOutput("t1BusyDone", 32'(busy), 1);
        tick();
        checkOutput("t1BusyIdle", 32'(busy), 0);

        // B alone in WAIT_A is ignored; simultaneous edges give 0.
        waitTag(400);
        applyStimulus(1, 0, 0, 0, 3'd0);
        waitTag(410);
        applyStimulus(0, 0, 0, 1, 3'd0);
        waitTag(420);
        expQ.push_back('{res: 0, due: 422});
        applyStimulus(0, 0, 1, 1, 3'd0);

        // Four pairs, diffs 10,12,14,16 -> 13.
        aTags = '{460, 490, 520, 550};
        diffs = '{10, 12, 14, 16};
        waitTag(450);
        applyStimulus(1, 0, 0, 0, 3'd2);
        for (int i = 0; i < 4; i++) begin
            waitTag(aTags[i]);
            applyStimulus(0, 0, 1, 0, 3'd2);
            waitTag(aTags[i] + diffs[i]);
            if (i == 3) begin
                expQ.push_back('{res: 13, due: 568});
            end
            applyStimulus(0, 0, 0, 1, 3'd2);
        end

        // navg=7 clamps to 4: sixteen pairs, diffs 5..20, sum 200 -> 12.
        waitTag(600);
        applyStimulus(1, 0, 0, 0, 3'd7);
        for (int i = 0; i < 16; i++) begin
            waitTag(620 + 30 * i);
            applyStimulus(0, 0, 1, 0, 3'd0);
            waitTag(620 + 30 * i + 5 + i);
            if (i == 15) begin
                expQ.push_back('{res: 12, due: 1092});
            end
            applyStimulus(0, 0, 0, 1, 3'd0);
        end

        // Timeout: WAIT_B entered at 1211, back in IDLE at 2211 with err.
        waitTag(1200);
        applyStimulus(1, 0, 0, 0, 3'd0);
        waitTag(1210);
        applyStimulus(0, 0, 1, 0, 3'd0);
        waitTag(2210);
        checkOutput("toBusyBefore", 32'(busy), 1);
        checkOutput("toErrBefore", 32'(err), 0);
        tick();
        checkOutput("toBusyAfter", 32'(busy), 0);
        checkOutput("toErr", 32'(err), 1);
        checkOutput("toResultHeld", 32'(result), 12);
        waitTag(2299);
        checkOutput("errSticky", 32'(err), 1);

        // Abort in WAIT_B together with a B edge; then abort+start in IDLE.
        applyStimulus(1, 0, 0, 0, 3'd0);
        checkOutput("startClearsErr", 32'(err), 0);
        waitTag(2310);
        applyStimulus(0, 0, 1, 0, 3'd0);
        waitTag(2330);
        applyStimulus(0, 1, 0, 1, 3'd0);
        checkOutput("abortBusy", 32'(busy), 0);
        checkOutput("abortResult", 32'(result), 12);
        checkOutput("abortErr", 32'(err), 0);
        waitTag(2340);
        applyStimulus(1, 1, 0, 0, 3'd0);
        checkOutput("abortOverStart", 32'(busy), 0);

        // Wrap: A at 65530, B at 20 -> 26, valid at 22.
        waitTag(65520);
        applyStimulus(1, 0, 0, 0, 3'd0);
        waitTag(65530);
        applyStimulus(0, 0, 1, 0, 3'd0);
        waitTag(20);
        expQ.push_back('{res: 26, due: 22});
        applyStimulus(0, 0, 0, 1, 3'd0);

        // Reset during ACCUM discards the measurement.
        waitTag(100);
        applyStimulus(1, 0, 0, 0, 3'd0);
        waitTag(110);
        applyStimulus(0, 0, 1, 0, 3'd0);
        waitTag(130);
        applyStimulus(0, 0, 0, 1, 3'd0);
        checkOutput("preRstResult", 32'(result), 26);
        checkOutput("preRstBusy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        checkOutput("midRstBusy", 32'(busy), 0);
        checkOutput("midRstResult", 32'(result), 0);
        checkOutput("midRstErr", 32'(err), 0);
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("postRstBusy", 32'(busy), 0);
        checkOutput("postRstResult", 32'(result), 0);
        checkOutput("pendingResults", 32'(expQ.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
